// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
//   Shared definitions for the ALU sequencing stage.
//   - OP_* : operation encodings, identical to what the ALU 's' input and
//            the instruction decoder use.
//   - state_t : sequencer states (IDLE, DIVW, EXEC).
package alu_ctrl_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DIVW = 2'b01,
        EXEC = 2'b10
    } state_t;

endpackage

// File: rtl/alu_ctrl.sv
// alu_ctrl
//   Sequencing stage in front of the Sextium III ALU. One request is
//   accepted per start pulse (only while idle). Operands and op are latched
//   and drive the ALU. DIV clocks the ALU divider pipeline through
//   alu_diven for DIV_LATENCY cycles. The ALU result is then captured into
//   res, and done pulses for one cycle.
//
// Ports
//   clock, reset_n        : clock and asynchronous active-low reset
//   start, op, opa, opb   : request strobe, operation and operands (ACC, DR)
//   busy                  : high while a request is in flight (state != IDLE)
//   done                  : one-cycle pulse, res/div_zero valid
//   res                   : registered result, held until next capture/reset
//   div_zero              : with done, flags DIV by zero (res forced to 0)
//   alu_a, alu_b, alu_s   : ALU dataa, datab, s
//   alu_diven             : ALU divider clock enable
//   alu_result            : ALU result
//   dbg_state             : current sequencer state, for observation
//
// Handshake: start is a single-cycle request sampled only in IDLE; a start
// seen in any other state is dropped. Completion is signalled only by the
// done pulse; there is no backpressure on the result.
module alu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DIV_LATENCY = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             div_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_s,
    output logic             alu_diven,
    input  logic [WIDTH-1:0] alu_result,
    output state_t           dbg_state
);

    localparam int CW = $clog2(DIV_LATENCY + 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic             r_dz;        // request is DIV with opb == 0
    logic             r_done;
    logic             r_div_zero;
    logic [WIDTH-1:0] r_res;

    logic             w_is_div;

    assign w_is_div = (r_op == OP_DIV);

    // The ALU computes datab/dataa for DIV, so operands are swapped to
    // yield opa/opb.
    assign alu_a     = w_is_div ? r_opb : r_opa;
    assign alu_b     = w_is_div ? r_opa : r_opb;
    assign alu_s     = r_op;
    assign alu_diven = (r_state == DIVW);

    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign res       = r_res;
    assign div_zero  = r_div_zero;
    assign dbg_state = r_state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_op       <= OP_ADD;
            r_opa      <= '0;
            r_opb      <= '0;
            r_dz       <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_res      <= '0;
        end else begin
            // done/div_zero are pulses; EXEC re-asserts them.
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op  <= op;
                        r_opa <= opa;
                        r_opb <= opb;
                        r_cnt <= '0;
                        if (op == OP_DIV && opb != '0) begin
                            r_dz    <= 1'b0;
                            r_state <= DIVW;
                        end else begin
                            // Divide by zero skips the divider entirely.
                            r_dz    <= (op == OP_DIV);
                            r_state <= EXEC;
                        end
                    end
                end
                DIVW: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(DIV_LATENCY - 1)) begin
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_res      <= r_dz ? '0 : alu_result;
                    r_div_zero <= r_dz;
                    r_done     <= 1'b1;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl.sv
module tb_alu_ctrl;
    import alu_ctrl_pkg::*;

    localparam int W  = 16;
    localparam int DL = 5;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] opa = '0;
    logic [W-1:0] opb = '0;
    logic         busy, done, div_zero, alu_diven;
    logic [W-1:0] res, alu_a, alu_b, alu_result;
    logic [1:0]   alu_s;
    state_t       dbg_state;

    int checks = 0;
    int errors = 0;

    // expected {div_zero, res}
    logic [W:0] exp_q[$];

    alu_ctrl #(.WIDTH(W), .DIV_LATENCY(DL)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .op(op),
        .opa(opa), .opb(opb), .busy(busy), .done(done), .res(res),
        .div_zero(div_zero), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
        .alu_diven(alu_diven), .alu_result(alu_result), .dbg_state(dbg_state)
    );

    // clock/reset
    always #5 clock = ~clock;

    // ALU model: combinational ADD/SUB/MUL, DL-stage clock-enabled divider
    logic [W-1:0] div_pipe [0:DL-1];
    logic [W-1:0] div_q;
    always_comb begin
        div_q = (alu_a == '0) ? 16'hDEAD : W'($signed(alu_b) / $signed(alu_a));
        case (alu_s)
            2'b00:   alu_result = alu_a + alu_b;
            2'b01:   alu_result = alu_a - alu_b;
            2'b10:   alu_result = W'(alu_a * alu_b);
            default: alu_result = div_pipe[DL-1];
        endcase
    end
    always @(posedge clock) begin
        if (alu_diven) begin
            div_pipe[0] <= div_q;
            for (int i = 1; i < DL; i++) div_pipe[i] <= div_pipe[i-1];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endtask

    // scoreboard monitor
    always @(negedge clock) begin
        if (reset_n && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0 @%0t", $time);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                check("res", 32'(res), 32'(e[W-1:0]));
                check("div_zero", 32'(div_zero), 32'(e[W]));
            end
        end
    end

    // driver: present a request for one cycle; returns in cycle 1
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic push, input logic [W:0] e);
        start = 1'b1; op = o; opa = a; opb = b;
        if (push) exp_q.push_back(e);
        @(posedge clock); #1;
        start = 1'b0; op = $urandom_range(0, 3); opa = W'($urandom); opb = W'($urandom);
    endtask

    // timing checks for cycles 1..dcyc (done in cycle dcyc); ends mid-cycle dcyc
    task automatic run_checks(input string tag, input int dcyc, input int div_cycles);
        for (int c = 1; c <= dcyc; c++) begin
            @(negedge clock);
            check({tag, "_busy"}, 32'(busy), 32'(c < dcyc));
            check({tag, "_done"}, 32'(done), 32'(c == dcyc));
            check({tag, "_diven"}, 32'(alu_diven), 32'(c >= 1 && c <= div_cycles));
            if (c < dcyc) begin
                @(posedge clock); #1;
            end
        end
    endtask

    initial begin
        // reset state
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_res", 32'(res), 32'd0);
        check("rst_dz", 32'(div_zero), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_alu_s", 32'(alu_s), 32'd0);
        check("rst_diven", 32'(alu_diven), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        // ADD 3+4 = 7
        issue(OP_ADD, 16'd3, 16'd4, 1'b1, {1'b0, 16'd7});
        run_checks("add", 2, 0);
        @(posedge clock); #1;

        // SUB 3-5 = FFFE, then MUL 300*300 = 90000 -> 5F90 started in done cycle
        issue(OP_SUB, 16'd3, 16'd5, 1'b1, {1'b0, 16'hFFFE});
        run_checks("sub", 2, 0);
        issue(OP_MUL, 16'd300, 16'd300, 1'b1, {1'b0, 16'h5F90});
        run_checks("mul", 2, 0);
        @(posedge clock); #1;

        // DIV 100/7 = 14, operands swapped toward the ALU
        issue(OP_DIV, 16'd100, 16'd7, 1'b1, {1'b0, 16'd14});
        check("div_alu_a", 32'(alu_a), 32'd7);
        check("div_alu_b", 32'(alu_b), 32'd100);
        check("div_alu_s", 32'(alu_s), 32'(OP_DIV));
        run_checks("div", DL + 2, DL);
        @(posedge clock); #1;

        // DIV -100/7 = -14
        issue(OP_DIV, 16'hFF9C, 16'd7, 1'b1, {1'b0, 16'hFFF2});
        run_checks("divneg", DL + 2, DL);
        @(posedge clock); #1;

        // DIV by zero
        issue(OP_DIV, 16'd5, 16'd0, 1'b1, {1'b1, 16'd0});
        run_checks("divz", 2, 0);
        @(posedge clock); #1;
        @(negedge clock);
        check("divz_clear", 32'(div_zero), 32'd0);
        check("divz_done_clear", 32'(done), 32'd0);
        check("res_hold", 32'(res), 32'd0);
        @(posedge clock); #1;

        // start while busy is ignored
        issue(OP_DIV, 16'd100, 16'd7, 1'b1, {1'b0, 16'd14});
        @(posedge clock); #1;              // cycle 2
        @(posedge clock); #1;              // cycle 3
        start = 1'b1; op = OP_ADD; opa = 16'd1; opb = 16'd1;
        @(posedge clock); #1;              // cycle 4
        start = 1'b0;
        check("ign_alu_s", 32'(alu_s), 32'(OP_DIV));
        check("ign_alu_a", 32'(alu_a), 32'd7);
        begin
            int n;
            n = 0;
            while (exp_q.size() != 0 && n < 20) begin
                @(posedge clock); #1;
                n++;
            end
            check("ign_timeout", 32'(exp_q.size()), 32'd0);
        end
        repeat (4) @(posedge clock);
        #1;

        // reset in cycle 3 of a DIV aborts it
        issue(OP_DIV, 16'd100, 16'd7, 1'b0, '0);
        @(posedge clock); #1;              // cycle 2
        @(posedge clock); #1;              // cycle 3
        reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diven", 32'(alu_diven), 32'd0);
        check("abort_res", 32'(res), 32'd0);
        check("abort_alu_b", 32'(alu_b), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (DL + 3) @(posedge clock);  // monitor flags any stray done
        #1;
        check("abort_state", 32'(dbg_state), 32'(IDLE));

        // new ADD after release
        issue(OP_ADD, 16'd10, 16'd20, 1'b1, {1'b0, 16'd30});
        run_checks("add2", 2, 0);
        @(posedge clock); #1;
        @(negedge clock);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // global time bound
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
